branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences the PC redirect and pipeline flush that follow each resolved branch or jump in EX.
- Consumes the Branch_unit decision (branch_output) with the ID/EX branch_sel and target address.
- Drives the PC mux select, the registered redirect target and the IF/ID and ID/EX flush strobes.
- Holds a redirect across memory stalls, drops wrong-path resolves, and keeps branch/taken statistics counters.

Parameters:
- XLEN, 32, address/target width.
- FLUSH_CYCLES, 2, total cycles flush strobes are asserted per redirect (legal range 1..15).
- COUNT_W, 16, width of the statistics counters.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- ex_valid  input  1  the ID/EX register holds a valid (non-bubble) instruction.
- branch_sel  input  4  branch select from ID/EX; bit3=1 marks a branch/jump.
- branch_output  input  1  Branch_unit decision: 1 means taken.
- branch_target  input  XLEN  computed target (PC+imm, or rs1+imm for JALR).
- stall  input  1  global pipeline stall (memory busy); freezes the PC and pipeline registers.
- pc_sel  output  1  1 means the PC loads pc_target.
- pc_target  output  XLEN  registered redirect address.
- flush_ifid  output  1  clear the IF/ID register.
- flush_idex  output  1  clear the ID/EX register.
- redirect_busy  output  1  state is not IDLE.
- branch_count  output  COUNT_W  resolved branches/jumps.
- taken_count  output  COUNT_W  taken branches/jumps.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE.
  - pc_sel, flush_ifid, flush_idex and redirect_busy are 0.
  - pc_target, flush counter, branch_count and taken_count are 0.
- All outputs are registered.
- resolve = ex_valid & branch_sel[3]; taken = resolve & branch_output.
- IDLE:
  - On a resolve with stall=0:
    - branch_count increments.
    - If taken: taken_count increments, pc_target <= branch_target, and the next state is REDIRECT.
  - On a resolve with stall=1:
    - Counters are not updated; the resolve is re-sampled on the first unstalled cycle.
    - Exception: taken with stall=1 captures pc_target and goes to PENDING; both counters increment on that capture edge.
- PENDING:
  - Outputs: redirect_busy=1, pc_sel=0, no flush.
  - The captured target is held.
  - On the first edge with stall=0, the next state is REDIRECT.
- REDIRECT (exactly one cycle):
  - Outputs: pc_sel=1, flush_ifid=1, flush_idex=1.
  - The flush counter loads FLUSH_CYCLES-1.
  - If FLUSH_CYCLES=1, the next state is IDLE; otherwise FLUSH.
  - If stall=1 during REDIRECT, the state and outputs hold until stall=0, so the PC load is never lost.
- FLUSH:
  - Outputs: flush_ifid=1, flush_idex=1, pc_sel=0.
  - The counter decrements on each unstalled edge and freezes while stall=1.
  - When the counter reaches 1 on an unstalled edge, the next state is IDLE.
- Wrong path: all resolve/taken inputs are ignored in PENDING, REDIRECT and FLUSH. They come from wrong-path instructions and are not counted.
- Latency: a taken resolve sampled at edge N (stall=0) gives pc_sel=1 in cycle N+1. Flush is asserted in cycles N+1 .. N+FLUSH_CYCLES.
- Counters saturate at all-ones and do not wrap.
- Not-taken resolves cause no state change.
- JAL/JALR (branch_sel=4'b1010) are treated like any taken branch.
- A reset assertion in any state returns to IDLE immediately. No redirect is issued after reset release.

Test Plan:
1. BEQ taken: ex_valid=1, branch_sel=4'b1000, branch_output=1, target=0x0000_0100, stall=0 at edge N.
   -> pc_sel=1 and pc_target=0x100 in cycle N+1; flush in N+1 and N+2; IDLE at N+3; branch_count=1, taken_count=1.
2. BNE not taken: branch_sel=4'b1001, branch_output=0.
   -> no pc_sel, no flush; branch_count=1, taken_count=0.
3. Taken JAL (4'b1010, target 0x200) with stall=1 for 3 cycles.
   -> PENDING for 3 cycles with redirect_busy=1; pc_sel=1 with 0x200 on the cycle after stall drops.
4. Stall=1 raised during the FLUSH cycle.
   -> flush stays asserted and the counter is frozen; total unstalled flush cycles still equal 2.
5. Back-to-back taken resolves in consecutive cycles.
   -> the second is ignored; exactly one redirect, taken_count=1.
6. RESET=0 asserted mid-REDIRECT.
   -> all outputs 0 asynchronously; after release the FSM is IDLE and no pc_sel pulse appears.
7. Counter saturation (COUNT_W=4): 20 taken branches.
   -> taken_count=4'hF.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Redirect/flush sequencer for branches and jumps resolved in EX.
// Issues one PC redirect per taken resolve, then flushes IF/ID and ID/EX, and keeps saturating statistics.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_W      = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ex_valid,
    input  logic [3:0]         branch_sel,
    input  logic               branch_output,
    input  logic [XLEN-1:0]    branch_target,
    input  logic               stall,
    output logic               pc_sel,
    output logic [XLEN-1:0]    pc_target,
    output logic               flush_ifid,
    output logic               flush_idex,
    output logic               redirect_busy,
    output logic [COUNT_W-1:0] branch_count,
    output logic [COUNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_REDIRECT,
        S_FLUSH
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_flush_cnt;
    logic [3:0]         w_flush_cnt_nxt;
    logic [XLEN-1:0]    r_pc_target;
    logic [XLEN-1:0]    w_pc_target_nxt;
    logic [COUNT_W-1:0] r_branch_cnt;
    logic [COUNT_W-1:0] w_branch_cnt_nxt;
    logic [COUNT_W-1:0] r_taken_cnt;
    logic [COUNT_W-1:0] w_taken_cnt_nxt;
    logic               r_pc_sel;
    logic               r_flush;
    logic               r_busy;
    logic               w_resolve;
    logic               w_taken;
    logic               w_unused_sel;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_resolve    = ex_valid & branch_sel[3];
    assign w_taken      = w_resolve & branch_output;
    assign w_unused_sel = ^branch_sel[2:0];

    // Resolves are only honoured in IDLE; anything seen while busy is wrong-path.
    always_comb begin
        w_next           = r_state;
        w_flush_cnt_nxt  = r_flush_cnt;
        w_pc_target_nxt  = r_pc_target;
        w_branch_cnt_nxt = r_branch_cnt;
        w_taken_cnt_nxt  = r_taken_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_resolve && !stall) begin
                    w_branch_cnt_nxt = sat_inc(r_branch_cnt);
                    if (w_taken) begin
                        w_taken_cnt_nxt = sat_inc(r_taken_cnt);
                        w_pc_target_nxt = branch_target;
                        w_next          = S_REDIRECT;
                    end
                end else if (w_taken && stall) begin
                    w_branch_cnt_nxt = sat_inc(r_branch_cnt);
                    w_taken_cnt_nxt  = sat_inc(r_taken_cnt);
                    w_pc_target_nxt  = branch_target;
                    w_next           = S_PENDING;
                end
            end
            S_PENDING: begin
                if (!stall) w_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (!stall) begin
                    w_flush_cnt_nxt = FLUSH_LOAD;
                    w_next          = (FLUSH_CYCLES == 1) ? S_IDLE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!stall) begin
                    w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                    if (r_flush_cnt == 4'd1) w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= S_IDLE;
            r_flush_cnt  <= '0;
            r_pc_target  <= '0;
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
            r_pc_sel     <= 1'b0;
            r_flush      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_pc_target  <= w_pc_target_nxt;
            r_branch_cnt <= w_branch_cnt_nxt;
            r_taken_cnt  <= w_taken_cnt_nxt;
            r_pc_sel     <= (w_next == S_REDIRECT);
            r_flush      <= (w_next == S_REDIRECT) || (w_next == S_FLUSH);
            r_busy       <= (w_next != S_IDLE);
        end
    end

    assign pc_sel        = r_pc_sel;
    assign pc_target     = r_pc_target;
    assign flush_ifid    = r_flush;
    assign flush_idex    = r_flush;
    assign redirect_busy = r_busy;
    assign branch_count  = r_branch_cnt;
    assign taken_count   = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios plus random traffic, scored against a
// countdown model of how many unstalled cycles each accepted redirect keeps the block busy.
module tb_branch_redirect_ctrl;

    localparam int XLEN = 32;
    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            ex_valid;
    logic [3:0]      branch_sel;
    logic            branch_output;
    logic [XLEN-1:0] branch_target;
    logic            stall;
    logic            pc_sel;
    logic [XLEN-1:0] pc_target;
    logic            flush_ifid;
    logic            flush_idex;
    logic            redirect_busy;
    logic [CW-1:0]   branch_count;
    logic [CW-1:0]   taken_count;

    branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .COUNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .ex_valid(ex_valid), .branch_sel(branch_sel),
        .branch_output(branch_output), .branch_target(branch_target), .stall(stall),
        .pc_sel(pc_sel), .pc_target(pc_target), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .redirect_busy(redirect_busy),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 CLK = ~CLK;

    // Reference model: m_busy = unstalled edges left before the block accepts a resolve again.
    int              m_busy = 0;
    int              m_bc   = 0;
    int              m_tc   = 0;
    logic [XLEN-1:0] exp_q[$];
    int              n_chk  = 0;
    int              n_err  = 0;
    bit              done   = 0;

    task automatic step(input logic ev, input logic [3:0] sel, input logic bo,
                        input logic [XLEN-1:0] tgt, input logic st);
        bit resolve;
        bit taken;
        ex_valid = ev; branch_sel = sel; branch_output = bo; branch_target = tgt; stall = st;
        @(posedge CLK);
        resolve = ev && sel[3];
        taken   = resolve && bo;
        if (RESET) begin
            if (m_busy == 0) begin
                if (resolve && !st) begin
                    if (m_bc < CMAX) m_bc++;
                    if (taken) begin
                        if (m_tc < CMAX) m_tc++;
                        exp_q.push_back(tgt);
                        m_busy = FC;
                    end
                end else if (taken && st) begin
                    if (m_bc < CMAX) m_bc++;
                    if (m_tc < CMAX) m_tc++;
                    exp_q.push_back(tgt);
                    m_busy = FC + 1;
                end
            end else if (!st) begin
                m_busy--;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, '0, st);
    endtask

    task automatic do_reset();
        RESET  = 1'b0;
        m_busy = 0;
        m_bc   = 0;
        m_tc   = 0;
        exp_q.delete();
        idle(2, 1'b0);
        RESET = 1'b1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: per-cycle output checks plus scoreboard pop on each committed redirect.
    initial begin
        logic [XLEN-1:0] e;
        forever begin
            @(negedge CLK);
            if (done) begin
                chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
                $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
                $finish;
            end
            chk("pc_sel",        64'(pc_sel),        64'(m_busy == FC));
            chk("flush_ifid",    64'(flush_ifid),    64'(m_busy != 0 && m_busy <= FC));
            chk("flush_idex",    64'(flush_idex),    64'(m_busy != 0 && m_busy <= FC));
            chk("redirect_busy", 64'(redirect_busy), 64'(m_busy != 0));
            chk("branch_count",  64'(branch_count),  64'(m_bc));
            chk("taken_count",   64'(taken_count),   64'(m_tc));
            if (!RESET) chk("pc_target_reset", 64'(pc_target), 64'd0);
            if (pc_sel && !stall && RESET) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_redirect", 64'(pc_target), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_target", 64'(pc_target), 64'(e));
                end
            end
        end
    end

    initial begin
        RESET = 1'b0; ex_valid = 1'b0; branch_sel = '0; branch_output = 1'b0;
        branch_target = '0; stall = 1'b0;
        do_reset();
        // BEQ taken, then BNE not taken
        step(1'b1, 4'b1000, 1'b1, 32'h0000_0100, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 4'b1001, 1'b0, 32'h0000_0180, 1'b0);
        idle(2, 1'b0);
        // JAL captured under a three-cycle stall
        step(1'b1, 4'b1010, 1'b1, 32'h0000_0200, 1'b1);
        idle(2, 1'b1);
        idle(4, 1'b0);
        // stall held during the flush cycle
        step(1'b1, 4'b1000, 1'b1, 32'h0000_0300, 1'b0);
        idle(1, 1'b0);
        idle(3, 1'b1);
        idle(3, 1'b0);
        // stall held during the redirect cycle
        step(1'b1, 4'b1000, 1'b1, 32'h0000_0340, 1'b0);
        idle(2, 1'b1);
        idle(3, 1'b0);
        // back-to-back taken: second is wrong-path
        step(1'b1, 4'b1000, 1'b1, 32'h0000_0400, 1'b0);
        step(1'b1, 4'b1000, 1'b1, 32'h0000_0500, 1'b0);
        idle(3, 1'b0);
        // asynchronous reset in the middle of a redirect
        step(1'b1, 4'b1000, 1'b1, 32'h0000_0600, 1'b0);
        do_reset();
        idle(3, 1'b0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
                 {$urandom_range(0, 32'hFFFF), 2'b00, 14'h0} ^ 32'($urandom & 32'hFFFC),
                 $urandom_range(0, 3) == 0);
        end
        idle(6, 1'b0);
        // saturation: 20 taken branches on a 4-bit counter
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'b1000, 1'b1, 32'h0000_1000 + 32'(i * 4), 1'b0);
            idle(FC, 1'b0);
        end
        idle(2, 1'b0);
        done = 1'b1;
        @(negedge CLK);
        #20;
        $display("FAIL monitor_timeout: summary not reached, required done handshake");
        $fatal(1, "monitor did not finish");
    end

endmodule
